strhw_msg_feeder: RTL
=====================

// Module: strhw_msg_feeder
// PURPOSE
// - Initiator for the Streebog control logic: accepts a host message as a 64-bit word stream,
//   packs 512-bit blocks, drives trg/block/size/last, reads state, returns the final hash.
// - Sits between host/bus adapter and control logic; one message in flight at a time.
// PARAMETERS
// - none; word width fixed at 64 (STRHW_WORD_BYTES=8), block at 512 (STRHW_BLOCK_BYTES=64)
// PORTS
// clk_i          in   1    clock
// rst_i          in   1    reset, synchronous, active-high
// s_data_i       in   64   message word; first message byte in [7:0]
// s_bytes_i      in   4    valid bytes in word, 8 except on s_last_i word (0..8)
// s_last_i       in   1    final word of message
// s_hash256_i    in   1    hash size (1=256, 0=512), sampled on first word of message
// s_valid_i      in   1    word valid
// s_ready_o      out  1    word accepted when s_valid_i&s_ready_o
// trg_o          out  1    one-cycle block submit pulse to control logic
// state_i        in   state_t  control logic state (CLEAR/BUSY/READY/DONE)
// block_o        out  512  block; word k in [64k+63:64k]; bytes past tail are zero
// block_size_o   out  6    valid bytes of final block (0..63); 0 for full blocks
// last_o         out  1    block is the message's final block
// hash_size_o    out  1    latched s_hash256_i
// hash_i         in   512  digest from control logic, valid in DONE
// h_data_o       out  512  digest; 256-bit mode: low 256 bits, upper bits zero
// h_valid_o      out  1    digest valid; held until h_ready_i
// h_ready_i      in   1    digest consumer ready
// BEHAVIOUR
// - Reset (sync): FSM->IDLE; s_ready_o, trg_o, last_o, h_valid_o = 0; block_o, block_size_o,
//   hash_size_o, h_data_o = 0; word index, byte counter cleared. Reset mid-message discards it.
// - Control-logic protocol: trg accepted only in CLEAR (first block) or READY; BUSY = processing;
//   DONE = hash_i valid; trg in DONE acknowledges and returns it to CLEAR.
// - FSM:
//   IDLE: wait state_i==CLEAR -> FILL.
//   FILL: s_ready_o=1; word i written to lane i, i++. 8th full word without last -> SEND(last=0).
//     Last word with bytes b: tail = 8*i+b; tail<64 -> SEND(last=1,size=tail);
//     tail==64 -> SEND(last=0) then EMPTY (all-zero block, size 0, last=1).
//   SEND: trg_o=1 exactly one cycle with block_o/size/last stable -> WAIT_ACC.
//   WAIT_ACC: hold block regs until state_i==BUSY or DONE (trg_o low) -> WAIT_PROC.
//   WAIT_PROC: state_i==READY and block not last -> clear lanes, i=0 -> FILL (or EMPTY pending);
//     state_i==DONE -> capture hash_i (masked per hash_size) -> OUT.
//   OUT: h_valid_o=1 until h_ready_i; on handshake -> ACK.
//   ACK: trg_o one cycle (ack of DONE), wait state_i==CLEAR -> IDLE.
// - s_ready_o=0 in every state except FILL; never accepts a word while a block is outstanding.
// - Latency: last word accepted -> trg_o next cycle; DONE seen -> h_valid_o next cycle.
// - Empty message (first word last, bytes 0): single block, size 0, last=1.
// - s_bytes_i<8 without s_last_i, or s_bytes_i=0 not on a block's first word: protocol error,
//   treated as last (block closes); bench must not rely on it.
// - h_ready_i high with h_valid_o low: ignored. state_i unexpected (e.g. CLEAR in WAIT_PROC): stay.
// STRUCTURE
// - strhw_common_types: state_t (existing), STRHW_BLOCK_BYTES=64, STRHW_WORD_BYTES=8,
//   feeder_state_t enum {IDLE,FILL,SEND,WAIT_ACC,WAIT_PROC,EMPTY,OUT,ACK}.
// - Sub-module strhw_block_assembler: lane index, byte count, tail zeroing, 512-bit packing.
// - Top: FSM, trg/ack pulse generation, hash capture/masking.
// TESTING (bench uses behavioural control-logic model, BUSY latency configurable)
// 1 empty msg, hash256=1: one word bytes=0 last -> one trg, block=0, size=0, last=1, hash_size=1;
//   h_data_o[511:256]=0.
// 2 63-byte msg (7 full + word bytes=7 last) -> one trg, size=63, last=1, block bytes 63 zero.
// 3 64-byte msg -> trg#1 size=0 last=0, trg#2 all-zero block size=0 last=1; exactly 2 pulses.
// 4 130-byte msg, BUSY held 20 cycles -> 3 trg (0/0, 0/0, 2/1); s_ready_o=0 throughout BUSY;
//   no word lost/duplicated; block words match stream order.
// 5 h_ready_i low 5 cycles in OUT -> h_valid_o/h_data_o stable; ack trg only after handshake.
// 6 rst_i pulsed mid-FILL (word 3) -> next cycle all outputs at reset values; new 16-byte msg
//   afterwards yields one block, size=16, no stale data from aborted message.

Source files
------------

// File: rtl/strhw_msg_feeder_pkg.sv
// Shared types and constants for the Streebog message feeder: control-logic state,
// feeder FSM encoding and block/word geometry.
package strhw_msg_feeder_pkg;

    localparam int unsigned StrhwBlockBytes = 64;
    localparam int unsigned StrhwWordBytes  = 8;
    localparam int unsigned StrhwWordWidth  = 8 * StrhwWordBytes;
    localparam int unsigned StrhwBlockWidth = 8 * StrhwBlockBytes;
    localparam int unsigned StrhwLanes      = StrhwBlockBytes / StrhwWordBytes;

    typedef enum logic [1:0] {
        StateClear,
        StateBusy,
        StateReady,
        StateDone
    } state_t;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StSend,
        StWaitAcc,
        StWaitProc,
        StEmpty,
        StOut,
        StAck
    } feeder_state_t;

    // Keep only the low 'bytes' bytes of a word; bytes past the message tail read as zero.
    function automatic logic [StrhwWordWidth-1:0] mask_word(
        input logic [StrhwWordWidth-1:0] data,
        input logic [3:0]                bytes
    );
        logic [StrhwWordWidth-1:0] m;
        m = '0;
        for (int k = 0; k < int'(StrhwWordBytes); k++) begin
            if (k < int'(bytes)) m[8*k +: 8] = 8'hff;
        end
        return data & m;
    endfunction

endpackage

// File: rtl/strhw_msg_feeder_if.sv
// Host-side bundle of the feeder: 64-bit message word stream in, digest handshake out.
interface strhw_msg_feeder_if;
    import strhw_msg_feeder_pkg::*;

    logic [StrhwWordWidth-1:0]  s_data;
    logic [3:0]                 s_bytes;
    logic                       s_last;
    logic                       s_hash256;
    logic                       s_valid;
    logic                       s_ready;
    logic [StrhwBlockWidth-1:0] h_data;
    logic                       h_valid;
    logic                       h_ready;

    modport master (
        output s_data, s_bytes, s_last, s_hash256, s_valid, h_ready,
        input  s_ready, h_data, h_valid
    );

    modport slave (
        input  s_data, s_bytes, s_last, s_hash256, s_valid, h_ready,
        output s_ready, h_data, h_valid
    );

endinterface

// File: rtl/strhw_msg_feeder_assembler.sv
// Packs accepted message words into the 512-bit block lanes, zeroing bytes past the tail,
// and reports the byte position the current word would close the block at.
module strhw_msg_feeder_assembler
    import strhw_msg_feeder_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       wr_i,
    input  logic [StrhwWordWidth-1:0]  data_i,
    input  logic [3:0]                 bytes_i,
    output logic [StrhwBlockWidth-1:0] block_o,
    output logic [3:0]                 idx_o,
    output logic [6:0]                 tail_o
);

    logic [StrhwWordWidth-1:0] lane_q [StrhwLanes];
    logic [3:0]                idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int k = 0; k < int'(StrhwLanes); k++) lane_q[k] <= '0;
            idx_q <= '0;
        end else if (wr_i && (idx_q < 4'(StrhwLanes))) begin
            lane_q[idx_q[2:0]] <= mask_word(data_i, bytes_i);
            idx_q              <= idx_q + 4'd1;
        end
    end

    always_comb begin
        block_o = '0;
        for (int k = 0; k < int'(StrhwLanes); k++) begin
            block_o[StrhwWordWidth*k +: StrhwWordWidth] = lane_q[k];
        end
    end

    assign idx_o  = idx_q;
    // Byte count of the block if the incoming word were written now.
    assign tail_o = {idx_q[2:0], 3'b000} + {3'b000, bytes_i};

endmodule

// File: rtl/strhw_msg_feeder.sv
// Streebog message feeder: turns a host word stream into 512-bit blocks for the control
// logic, sequences trg/ack against its state, and returns the (masked) digest.
module strhw_msg_feeder
    import strhw_msg_feeder_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    strhw_msg_feeder_if.slave          host,
    output logic                       trg_o,
    input  state_t                     state_i,
    output logic [StrhwBlockWidth-1:0] block_o,
    output logic [5:0]                 block_size_o,
    output logic                       last_o,
    output logic                       hash_size_o,
    input  logic [StrhwBlockWidth-1:0] hash_i
);

    localparam int unsigned HalfWidth = StrhwBlockWidth / 2;

    feeder_state_t              st_q, st_d;
    logic                       last_q, last_d;
    logic [5:0]                 size_q, size_d;
    logic                       hash_size_q, hash_size_d;
    logic [StrhwBlockWidth-1:0] h_data_q, h_data_d;
    logic                       empty_pend_q, empty_pend_d;
    logic                       first_q, first_d;
    logic                       ack_done_q, ack_done_d;

    logic       accept;
    logic       closing;
    logic       clear;
    logic [3:0] idx;
    logic [6:0] tail;

    strhw_msg_feeder_assembler u_assembler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear),
        .wr_i    (accept),
        .data_i  (host.s_data),
        .bytes_i (host.s_bytes),
        .block_o (block_o),
        .idx_o   (idx),
        .tail_o  (tail)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q         <= StIdle;
            last_q       <= 1'b0;
            size_q       <= '0;
            hash_size_q  <= 1'b0;
            h_data_q     <= '0;
            empty_pend_q <= 1'b0;
            first_q      <= 1'b0;
            ack_done_q   <= 1'b0;
        end else begin
            st_q         <= st_d;
            last_q       <= last_d;
            size_q       <= size_d;
            hash_size_q  <= hash_size_d;
            h_data_q     <= h_data_d;
            empty_pend_q <= empty_pend_d;
            first_q      <= first_d;
            ack_done_q   <= ack_done_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        last_d       = last_q;
        size_d       = size_q;
        hash_size_d  = hash_size_q;
        h_data_d     = h_data_q;
        empty_pend_d = empty_pend_q;
        first_d      = first_q;
        ack_done_d   = ack_done_q;
        clear        = 1'b0;
        accept       = (st_q == StFill) && host.s_valid;
        // A short word closes the block even without s_last (malformed input).
        closing      = host.s_last || (host.s_bytes != 4'd8);

        unique case (st_q)
            StIdle: begin
                clear   = 1'b1;
                first_d = 1'b1;
                if (state_i == StateClear) st_d = StFill;
            end
            StFill: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (first_q) hash_size_d = host.s_hash256;
                    if (closing) begin
                        st_d = StSend;
                        if (tail == 7'd64) begin
                            size_d       = '0;
                            last_d       = 1'b0;
                            empty_pend_d = 1'b1;
                        end else begin
                            size_d = tail[5:0];
                            last_d = 1'b1;
                        end
                    end else if (idx == 4'd7) begin
                        st_d   = StSend;
                        size_d = '0;
                        last_d = 1'b0;
                    end
                end
            end
            StSend: st_d = StWaitAcc;
            StWaitAcc: begin
                if (state_i == StateBusy || state_i == StateDone) st_d = StWaitProc;
            end
            StWaitProc: begin
                if (state_i == StateDone) begin
                    h_data_d = hash_size_q ? {{HalfWidth{1'b0}}, hash_i[HalfWidth-1:0]} : hash_i;
                    st_d     = StOut;
                end else if (state_i == StateReady && !last_q) begin
                    clear = 1'b1;
                    st_d  = empty_pend_q ? StEmpty : StFill;
                end
            end
            StEmpty: begin
                size_d       = '0;
                last_d       = 1'b1;
                empty_pend_d = 1'b0;
                st_d         = StSend;
            end
            StOut: begin
                ack_done_d = 1'b0;
                if (host.h_ready) st_d = StAck;
            end
            StAck: begin
                ack_done_d = 1'b1;
                if (ack_done_q && state_i == StateClear) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    assign host.s_ready = (st_q == StFill);
    assign host.h_valid = (st_q == StOut);
    assign host.h_data  = h_data_q;
    assign trg_o        = (st_q == StSend) || ((st_q == StAck) && !ack_done_q);
    assign block_size_o = size_q;
    assign last_o       = last_q;
    assign hash_size_o  = hash_size_q;

endmodule
